// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the minisys 32 instruction fetch stage.
// Reset vector, FSM encodings and J-type field ranges.
package ifetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned IADDR_W_DEF  = 14;

  localparam int unsigned JT_MSB = 25;
  localparam int unsigned JT_LSB = 0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] add4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Next-PC selection for the fetch stage.
// Priority: Jr, then Jmp/Jal, then taken branch, then sequential.
module npc_calc
  import ifetch_unit_pkg::*;
(
  input  logic [31:0]     pc,
  input  logic [JT_MSB:0] jidx,
  input  logic            jr,
  input  logic            jmp,
  input  logic            jal,
  input  logic            branch,
  input  logic            nbranch,
  input  logic            zero,
  input  logic [29:0]     imme,
  input  logic [31:0]     jr_addr,
  output logic [31:0]     npc,
  output logic            jr_misalign
);

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic        br_taken;

  assign pc_plus4  = add4(pc);
  assign br_target = pc_plus4 + {imme, 2'b00};
  assign br_taken  = (branch & zero) | (nbranch & ~zero);

  always_comb begin
    npc         = pc_plus4;
    jr_misalign = 1'b0;
    if (jr) begin
      npc         = {jr_addr[31:2], 2'b00};
      jr_misalign = |jr_addr[1:0];
    end else if (jmp | jal) begin
      npc = {pc_plus4[31:28], jidx[JT_MSB:JT_LSB], 2'b00};
    end else if (br_taken) begin
      npc = br_target;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem handshake, Inst hold
// and retire bookkeeping for the minisys 32 pipeline.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IADDR_W  = IADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               Jr,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               zero,
  input  logic [31:0]        Imme,
  input  logic [31:0]        jr_addr,
  output logic [31:0]        Inst,
  output logic               inst_valid,
  output logic [31:0]        pc,
  output logic [31:0]        link_addr,
  output logic               misalign_err,
  output logic [31:0]        retired_cnt
);

  fetch_state_t state, state_nxt;
  logic [31:0]  npc;
  logic         jr_misalign;
  logic         accept;
  logic         retire;
  logic [1:0]   unused_imme;

  assign unused_imme = Imme[31:30];

  npc_calc u_npc (
    .pc          (pc),
    .jidx        (Inst[JT_MSB:JT_LSB]),
    .jr          (Jr),
    .jmp         (Jmp),
    .jal         (Jal),
    .branch      (Branch),
    .nbranch     (nBranch),
    .zero        (zero),
    .imme        (Imme[29:0]),
    .jr_addr     (jr_addr),
    .npc         (npc),
    .jr_misalign (jr_misalign)
  );

  assign imem_addr = pc[IADDR_W+1:2];

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    accept    = 1'b0;
    retire    = 1'b0;
    unique case (state)
      S_BOOT: state_nxt = S_WAIT;
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          accept    = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          retire    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BOOT;
    else     state <= state_nxt;
  end

  // Redirect controls only matter at the retiring edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Inst         <= 32'd0;
      inst_valid   <= 1'b0;
      pc           <= RESET_PC;
      link_addr    <= add4(RESET_PC);
      misalign_err <= 1'b0;
      retired_cnt  <= 32'd0;
    end else if (accept) begin
      Inst       <= imem_rdata;
      inst_valid <= 1'b1;
    end else if (retire) begin
      pc          <= npc;
      link_addr   <= add4(npc);
      retired_cnt <= retired_cnt + 32'd1;
      inst_valid  <= 1'b0;
      if (jr_misalign) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit.
// Inputs change on negedge, outputs are sampled on negedge.
module tb_ifetch_unit;

  localparam int IW = 14;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [IW-1:0] imem_addr;
  logic          imem_ready;
  logic [31:0]   imem_rdata;
  logic          stall;
  logic          Jr, Jmp, Jal, Branch, nBranch, zero;
  logic [31:0]   Imme, jr_addr;
  logic [31:0]   Inst;
  logic          inst_valid;
  logic [31:0]   pc;
  logic [31:0]   link_addr;
  logic          misalign_err;
  logic [31:0]   retired_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0), .IADDR_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .Jr           (Jr),
    .Jmp          (Jmp),
    .Jal          (Jal),
    .Branch       (Branch),
    .nBranch      (nBranch),
    .zero         (zero),
    .Imme         (Imme),
    .jr_addr      (jr_addr),
    .Inst         (Inst),
    .inst_valid   (inst_valid),
    .pc           (pc),
    .link_addr    (link_addr),
    .misalign_err (misalign_err),
    .retired_cnt  (retired_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_ctl();
    Jr = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0;
    zero = 0; Imme = 0; jr_addr = 0;
  endtask

  // Waits for a request, holds ready low dly cycles, then delivers instr.
  task automatic fetch(input logic [31:0] instr, input int dly,
                       input logic [31:0] epc);
    logic [IW-1:0] a0;
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    if (!imem_req) begin
      check("req_timeout", {31'd0, imem_req}, 32'd1);
      return;
    end
    a0 = imem_addr;
    if (dly > 0) check("fetch_addr", {18'd0, a0}, {18'd0, epc[IW+1:2]});
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (imem_addr !== a0 || !imem_req)
        check("addr_stable", {18'd0, imem_addr}, {18'd0, a0});
    end
    imem_ready = 1; imem_rdata = instr;
    @(negedge clk);
    imem_ready = 0; imem_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic retire();
    stall = 0;
    @(negedge clk);
    stall = 1;
    clr_ctl();
  endtask

  task automatic nop_step();
    fetch(NOP, 0, 32'h0);
    retire();
  endtask

  task automatic jr_step(input logic [31:0] tgt);
    fetch(NOP, 0, 32'h0);
    Jr = 1; jr_addr = tgt;
    retire();
  endtask

  logic [31:0] c0;

  initial begin
    rst = 1; imem_ready = 0; imem_rdata = 0; stall = 1;
    clr_ctl();
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_link", link_addr, 32'h4);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", Inst, 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    rst = 0;

    // 1: sequential NOPs
    for (int i = 0; i < 3; i++) begin
      fetch(32'h1111_0000 + i, 0, 32'h0);
      check("seq_valid", {31'd0, inst_valid}, 32'd1);
      check("seq_inst", Inst, 32'h1111_0000 + i);
      check("seq_pc", pc, 32'(4 * i));
      retire();
    end
    check("seq_cnt", retired_cnt, 32'd3);
    check("seq_pc3", pc, 32'hC);

    // 2: branches
    jr_step(32'h100);
    check("jr_100", pc, 32'h100);
    check("jr_link", link_addr, 32'h104);
    fetch(NOP, 0, 32'h0);
    Branch = 1; zero = 1; Imme = 32'hFFFF_FFFE;
    retire();
    check("beq_taken", pc, 32'hFC);
    jr_step(32'h100);
    fetch(NOP, 0, 32'h0);
    Branch = 1; zero = 0; Imme = 32'hFFFF_FFFE;
    retire();
    check("beq_not", pc, 32'h104);
    fetch(NOP, 0, 32'h0);
    nBranch = 1; zero = 0; Imme = 32'h4;
    retire();
    check("bne_taken", pc, 32'h118);

    // 3: Jal
    jr_step(32'h1000_0010);
    fetch(32'h0C00_0040, 0, 32'h0);
    check("jal_link", link_addr, 32'h1000_0014);
    Jal = 1;
    retire();
    check("jal_pc", pc, 32'h1000_0100);
    check("no_mis", {31'd0, misalign_err}, 32'd0);

    // 4: misaligned Jr, sticky error, Jr over Jmp
    jr_step(32'h203);
    check("jr_mis_pc", pc, 32'h200);
    check("jr_mis_err", {31'd0, misalign_err}, 32'd1);
    for (int i = 0; i < 10; i++) nop_step();
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);
    check("mis_pc", pc, 32'h228);
    fetch(32'h0800_0010, 0, 32'h0);
    Jr = 1; Jmp = 1; jr_addr = 32'h300;
    retire();
    check("jr_over_jmp", pc, 32'h300);

    // 5: stall and delayed ready
    fetch(32'hCAFE_0001, 3, 32'h300);
    c0 = retired_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pc !== 32'h300 || Inst !== 32'hCAFE_0001 ||
          retired_cnt !== c0 || !inst_valid)
        check("stall_hold", pc, 32'h300);
    end
    check("stall_pc", pc, 32'h300);
    check("stall_cnt", retired_cnt, c0);
    check("stall_inst", Inst, 32'hCAFE_0001);
    retire();
    check("stall_ret_pc", pc, 32'h304);
    check("stall_ret_cnt", retired_cnt, c0 + 1);

    // 6: reset mid-fetch, late ready ignored, PC wrap
    jr_step(32'h40);
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    check("pre_rst_pc", pc, 32'h40);
    rst = 1;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_cnt", retired_cnt, 32'd0);
    check("async_mis", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    rst = 0;
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ready = 0;
    check("late_valid", {31'd0, inst_valid}, 32'd0);
    check("late_inst", Inst, 32'd0);
    check("late_req", {31'd0, imem_req}, 32'd1);
    jr_step(32'hFFFF_FFFC);
    check("wrap_link", link_addr, 32'h0);
    nop_step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_cnt", retired_cnt, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
